// File: rtl/data_cache_dm_if.sv
// CPU-side and backing-memory signals of the direct-mapped data cache.
// slave = cache side, master = CPU plus backing-memory environment.
interface data_cache_dm_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [1:0]        MEM;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] Wdata;
  logic [DATA_W-1:0] Rdata;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  MEM, Addr, Wdata, mem_ack, mem_rdata,
    output Rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output MEM, Addr, Wdata, mem_ack, mem_rdata,
    input  Rdata, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_cache_dm.sv
// Direct-mapped, write-through, read-allocate data cache with 0-cycle read hits.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module data_cache_dm #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINES  = 64,
  parameter int unsigned WPL    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  data_cache_dm_if.slave       bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);
  localparam int unsigned OFF_W = $clog2(WPL);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WPL - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t             state;
  logic [OFF_W-1:0]   beat;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic               req_q;
  logic               we_q;

  logic [DATA_W-1:0]  data_q [LINES*WPL];
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [LINES-1:0]   valid_q;

  logic [OFF_W-1:0]   cpu_off;
  logic [IDX_W-1:0]   cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic               cpu_hit;
  logic [OFF_W-1:0]   lat_off;
  logic [IDX_W-1:0]   lat_idx;
  logic [TAG_W-1:0]   lat_tag;
  logic               lat_hit;
  logic               is_write;
  logic               is_read;

  assign cpu_off  = bus.Addr[OFF_W-1:0];
  assign cpu_idx  = bus.Addr[OFF_W +: IDX_W];
  assign cpu_tag  = bus.Addr[ADDR_W-1 -: TAG_W];
  assign cpu_hit  = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign lat_off  = lat_addr[OFF_W-1:0];
  assign lat_idx  = lat_addr[OFF_W +: IDX_W];
  assign lat_tag  = lat_addr[ADDR_W-1 -: TAG_W];
  assign lat_hit  = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);
  assign is_write = bus.MEM[1];
  assign is_read  = bus.MEM[0] && !bus.MEM[1];

  // Backing-bus drive: fill beats walk the line in order, writes use the latched word.
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = (state == FILL) ? {lat_addr[ADDR_W-1:OFF_W], beat} : lat_addr;
  assign bus.mem_wdata = lat_wdata;

  // CPU-side response: hit data and stall are decided in the same cycle.
  always_comb begin
    bus.stall = 1'b0;
    bus.Rdata = '0;
    case (state)
      IDLE: begin
        if (is_write) begin
          bus.stall = 1'b1;
        end else if (is_read) begin
          if (cpu_hit) bus.Rdata = data_q[{cpu_idx, cpu_off}];
          else         bus.stall = 1'b1;
        end
      end
      FILL:    bus.stall = 1'b1;
      WRITE:   bus.stall = !bus.mem_ack;
      default: bus.stall = 1'b0;
    endcase
  end

  // Control FSM, valid bits and bus request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      valid_q   <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_write) begin
            lat_addr  <= bus.Addr;
            lat_wdata <= bus.Wdata;
            req_q     <= 1'b1;
            we_q      <= 1'b1;
            state     <= WRITE;
          end else if (is_read && !cpu_hit) begin
            lat_addr          <= bus.Addr;
            beat              <= '0;
            valid_q[cpu_idx]  <= 1'b0;
            req_q             <= 1'b1;
            we_q              <= 1'b0;
            state             <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            beat <= OFF_W'(beat + 1'b1);
            if (beat == LAST_BEAT) begin
              valid_q[lat_idx] <= 1'b1;
              req_q            <= 1'b0;
              state            <= IDLE;
            end
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag arrays are never cleared; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst && bus.mem_ack) begin
      if (state == FILL) begin
        data_q[{lat_idx, beat}] <= bus.mem_rdata;
        if (beat == LAST_BEAT) tag_q[lat_idx] <= lat_tag;
      end else if (state == WRITE && lat_hit) begin
        data_q[{lat_idx, lat_off}] <= lat_wdata;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == IDLE && is_read) begin
      if (cpu_hit) hit_cnt  <= hit_cnt + 32'd1;
      else         miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
